dly_tap_ctrl: RTL and testbench
===============================

Name: dly_tap_ctrl

Overview:
Owns the 20 six-bit delay tap registers feeding the delay-value multiplexer and drives its address select. Accepts one command at a time (load, increment, decrement, read) over a valid/ready port and applies it to the addressed channel. After every write it waits a programmable settle interval, then returns a response. Sits between the I/O-delay calibration logic and the tap-value mux / delay lines.

Parameters:
NUM_TAPS, 20, number of delay channels (1..32); addresses >= NUM_TAPS are illegal.
SETTLE_CYCLES, 4, post-update wait in clock cycles (1..255).
RESET_TAP, 6'd0, tap value loaded into every channel on reset.

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  controller can accept a command
CMD_OP  in  2  0=LOAD, 1=INC, 2=DEC, 3=READ
CMD_ADDR  in  5  target channel
CMD_DATA  in  6  load value (LOAD only)
RSP_VALID  out  1  one-cycle response strobe
RSP_DATA  out  6  channel tap value after the operation
RSP_ERR  out  1  illegal address, or INC/DEC saturated
DLY_ADDR  out  5  select to tap-value mux = last addressed channel
DLY_TAP_VAL_BUS  out  6*NUM_TAPS  channel n at bits [6n+5:6n]
BUSY  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert internally): all taps = RESET_TAP; state IDLE; CMD_READY=1; RSP_VALID=0; RSP_DATA=0; RSP_ERR=0; DLY_ADDR=0; BUSY=0.
- Command handshake: accepted on a cycle with CMD_VALID & CMD_READY. CMD_READY=1 only in IDLE. Command fields are captured at acceptance; later changes are ignored.
- FSM states: IDLE, APPLY, SETTLE, RESP.
  - IDLE: on accept, go to APPLY.
  - APPLY: one cycle. Checks the address and updates the tap. DLY_ADDR <= captured addr if legal, otherwise unchanged.
    - READ or error: go to RESP.
    - Write: counter <= SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: decrement the counter; at 0, go to RESP.
  - RESP: RSP_VALID=1 for exactly one cycle, then IDLE.
- Latency from accept edge to RSP_VALID high:
  - READ or error: 2 cycles.
  - Write: 2+SETTLE_CYCLES cycles.
- Next accept is possible on the cycle after RESP (CMD_READY rises with return to IDLE).
- Operations on a legal address:
  - LOAD: tap <= CMD_DATA.
  - INC: tap <= tap+1, saturating at 63. If already 63, no change and RSP_ERR=1.
  - DEC: tap <= tap-1, saturating at 0. If already 0, no change and RSP_ERR=1.
  - READ: no change.
  - RSP_DATA = resulting tap value.
- Illegal address (>= NUM_TAPS): no tap changes, DLY_ADDR unchanged, RSP_ERR=1, RSP_DATA=0, SETTLE skipped.
- RSP_DATA/RSP_ERR hold their value until the next RESP.
- DLY_TAP_VAL_BUS updates in the APPLY cycle (registered; visible the cycle after APPLY) and is stable at all other times.
- Reset mid-operation: command dropped, no response, all state returns to reset values immediately.
- CMD_VALID while busy: held off by CMD_READY=0; no command is lost or duplicated.

Test Plan:
1. Reset with RESET_TAP=0 -> every bus field 0, CMD_READY=1, DLY_ADDR=0. LOAD addr 5, data 6'd37 -> bus[35:30]=37 the cycle after APPLY; RSP_VALID exactly 6 cycles after accept (SETTLE_CYCLES=4); RSP_DATA=37; RSP_ERR=0; DLY_ADDR=5.
2. LOAD ch 19 with 62, then INC, INC -> first response 63/ERR=0, second 63/ERR=1. LOAD ch 0 with 0, then DEC -> RSP_DATA=0, ERR=1.
3. READ addr 19 after case 2 -> RSP_VALID 2 cycles after accept, RSP_DATA=63, bus unchanged. READ addr 20 -> ERR=1, RSP_DATA=0, DLY_ADDR stays at previous value.
4. CMD_VALID held high continuously with 3 back-to-back INCs on ch 7 -> exactly 3 accepts spaced 7 cycles apart, final tap 3, 3 RSP_VALID pulses.
5. Assert RESET during SETTLE of a LOAD 50 to ch 3 -> ch 3 reads RESET_TAP, no RSP_VALID, BUSY=0 immediately. The next command is accepted normally.
6. SETTLE_CYCLES=1 build -> write response 3 cycles after accept. Randomised op/addr sequence checked against a scoreboard model of all 20 taps.

Source files
------------

// File: rtl/dly_tap_ctrl_if.sv
// Command/response port and tap-bus outputs between the calibration logic
// and the delay tap controller.
interface dly_tap_ctrl_if #(parameter int NUM_TAPS = 20);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [4:0]            cmd_addr;
   logic [5:0]            cmd_data;
   logic                  rsp_valid;
   logic [5:0]            rsp_data;
   logic                  rsp_err;
   logic [4:0]            dly_addr;
   logic [6*NUM_TAPS-1:0] dly_tap_val_bus;
   logic                  busy;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, dly_addr, dly_tap_val_bus, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, dly_addr, dly_tap_val_bus, busy
   );
endinterface

// File: rtl/dly_tap_ctrl.sv
// Delay tap controller: owns NUM_TAPS six-bit tap registers, applies one
// LOAD/INC/DEC/READ command at a time and answers after a settle interval.
module dly_tap_lane #(
   parameter logic [5:0] RESET_TAP = 6'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [5:0] din,
   output logic [5:0] tap
);
   always_ff @(posedge clk or posedge rst)
      if (rst)     tap <= RESET_TAP;
      else if (we) tap <= din;
endmodule

module dly_tap_ctrl #(
   parameter int         NUM_TAPS      = 20,
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [5:0] RESET_TAP     = 6'd0
) (
   input logic           clk,
   input logic           rst,
   dly_tap_ctrl_if.slave bus_if
);
   typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RESP} state_t;
   typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_DEC, OP_READ} op_t;
   typedef struct packed { op_t op; logic [4:0] addr; logic [5:0] data; } cmd_t;
   typedef struct packed { logic [5:0] data; logic err; } rsp_t;

   localparam logic [5:0] NT6 = 6'(NUM_TAPS);

   // Assert immediately, release two edges after the external reset drops.
   logic [1:0] rst_q;
   logic       rst_i;
   always_ff @(posedge clk or posedge rst)
      if (rst) rst_q <= 2'b11;
      else     rst_q <= {rst_q[0], 1'b0};
   assign rst_i = rst_q[1];

   state_t                   state;
   cmd_t                     cmd_q;
   rsp_t                     res_q;
   logic [7:0]               cnt;
   logic [NUM_TAPS-1:0][5:0] taps;
   logic [NUM_TAPS-1:0]      lane_we;
   logic                     legal, sat, do_write;
   logic [5:0]               cur_tap, new_tap;

   assign legal = {1'b0, cmd_q.addr} < NT6;

   always_comb begin
      cur_tap = '0;
      for (int i = 0; i < NUM_TAPS; i++)
         if (5'(i) == cmd_q.addr) cur_tap = taps[i];
   end

   always_comb begin
      sat     = 1'b0;
      new_tap = cur_tap;
      case (cmd_q.op)
         OP_LOAD: new_tap = cmd_q.data;
         OP_INC: begin
            sat = &cur_tap;
            if (!sat) new_tap = cur_tap + 6'd1;
         end
         OP_DEC: begin
            sat = ~|cur_tap;
            if (!sat) new_tap = cur_tap - 6'd1;
         end
         default: ;
      endcase
   end

   // Saturated INC/DEC counts as an error: no write and no settle wait.
   assign do_write = (state == APPLY) && legal && (cmd_q.op != OP_READ) && !sat;

   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_lane
      assign lane_we[g] = do_write && (cmd_q.addr == 5'(g));
      dly_tap_lane #(.RESET_TAP(RESET_TAP)) u_lane (
         .clk (clk),
         .rst (rst_i),
         .we  (lane_we[g]),
         .din (new_tap),
         .tap (taps[g])
      );
   end

   assign bus_if.dly_tap_val_bus = taps;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         cmd_q            <= '0;
         res_q            <= '0;
         cnt              <= '0;
         bus_if.cmd_ready <= 1'b1;
         bus_if.rsp_valid <= 1'b0;
         bus_if.rsp_data  <= '0;
         bus_if.rsp_err   <= 1'b0;
         bus_if.dly_addr  <= '0;
         bus_if.busy      <= 1'b0;
      end else begin
         bus_if.rsp_valid <= 1'b0;
         case (state)
            IDLE: if (bus_if.cmd_valid && bus_if.cmd_ready) begin
               cmd_q.op         <= op_t'(bus_if.cmd_op);
               cmd_q.addr       <= bus_if.cmd_addr;
               cmd_q.data       <= bus_if.cmd_data;
               bus_if.cmd_ready <= 1'b0;
               bus_if.busy      <= 1'b1;
               state            <= APPLY;
            end
            APPLY: begin
               res_q.data <= legal ? new_tap : 6'd0;
               res_q.err  <= !legal || sat;
               if (legal) bus_if.dly_addr <= cmd_q.addr;
               if (do_write) begin
                  cnt   <= 8'(SETTLE_CYCLES - 1);
                  state <= SETTLE;
               end else begin
                  state <= RESP;
               end
            end
            SETTLE: begin
               if (cnt == 8'd0) state <= RESP;
               else             cnt   <= cnt - 8'd1;
            end
            default: begin
               bus_if.rsp_valid <= 1'b1;
               bus_if.rsp_data  <= res_q.data;
               bus_if.rsp_err   <= res_q.err;
               bus_if.cmd_ready <= 1'b1;
               bus_if.busy      <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Bench for dly_tap_ctrl: directed table, back-to-back, mid-op reset and a
// randomised run on a SETTLE_CYCLES=1 instance, all against a scoreboard.
module tb_dly_tap_ctrl;
   localparam int NT = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dly_tap_ctrl_if #(.NUM_TAPS(NT)) if4 ();
   dly_tap_ctrl_if #(.NUM_TAPS(NT)) if1 ();

   dly_tap_ctrl #(.NUM_TAPS(NT), .SETTLE_CYCLES(4), .RESET_TAP(6'd0)) dut4 (
      .clk(clk), .rst(rst), .bus_if(if4));
   dly_tap_ctrl #(.NUM_TAPS(NT), .SETTLE_CYCLES(1), .RESET_TAP(6'd0)) dut1 (
      .clk(clk), .rst(rst), .bus_if(if1));

   // sel picks which instance the stimulus and checks talk to
   logic       sel = 1'b0;
   logic       v_valid = 1'b0;
   logic [1:0] v_op = '0;
   logic [4:0] v_addr = '0;
   logic [5:0] v_data = '0;

   assign if4.cmd_valid = v_valid & ~sel;
   assign if1.cmd_valid = v_valid & sel;
   assign if4.cmd_op = v_op;   assign if1.cmd_op = v_op;
   assign if4.cmd_addr = v_addr; assign if1.cmd_addr = v_addr;
   assign if4.cmd_data = v_data; assign if1.cmd_data = v_data;

   wire          s_ready     = sel ? if1.cmd_ready : if4.cmd_ready;
   wire          s_rsp_valid = sel ? if1.rsp_valid : if4.rsp_valid;
   wire [5:0]    s_rsp_data  = sel ? if1.rsp_data  : if4.rsp_data;
   wire          s_rsp_err   = sel ? if1.rsp_err   : if4.rsp_err;
   wire [4:0]    s_dly_addr  = sel ? if1.dly_addr  : if4.dly_addr;
   wire          s_busy      = sel ? if1.busy      : if4.busy;
   wire [6*NT-1:0] s_bus     = sel ? if1.dly_tap_val_bus : if4.dly_tap_val_bus;

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   int npulse = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [5:0] data;
      logic       err;
      int         lat;
      logic [4:0] dly;
      int         acc;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [1:0] op;
      logic [4:0] addr;
      logic [5:0] data;
      logic [5:0] xd;
      logic       xe;
      int         lat;
      logic [4:0] xdly;
   } vec_t;
   vec_t tbl[11];

   // reference model
   logic [5:0] mtap [32];
   logic [4:0] mdly;
   int         msettle = 4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mtap[i] = 6'd0;
      mdly = 5'd0;
   endfunction

   function automatic exp_t model(input logic [1:0] op, input logic [4:0] addr, input logic [5:0] data);
      exp_t e;
      e.acc = 0;
      if (int'(addr) >= NT) begin
         e.data = 6'd0; e.err = 1'b1; e.lat = 2;
      end else begin
         e.err = 1'b0;
         case (op)
            2'd0: mtap[addr] = data;
            2'd1: if (mtap[addr] == 6'd63) e.err = 1'b1; else mtap[addr] = mtap[addr] + 6'd1;
            2'd2: if (mtap[addr] == 6'd0)  e.err = 1'b1; else mtap[addr] = mtap[addr] - 6'd1;
            default: ;
         endcase
         e.data = mtap[addr];
         mdly = addr;
         e.lat = (op != 2'd3 && !e.err) ? 2 + msettle : 2;
      end
      e.dly = mdly;
      return e;
   endfunction

   always @(negedge clk) begin
      if (s_rsp_valid === 1'b1) begin
         exp_t e;
         npulse++;
         if (sbq.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL rsp_unexpected: got a response strobe, expected none (t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            chk("rsp_data", s_rsp_data, e.data);
            chk("rsp_err", s_rsp_err, e.err);
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("dly_addr", s_dly_addr, e.dly);
         end
      end
   end

   task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [5:0] data, input exp_t e);
      int k;
      int a;
      a = int'(addr);
      @(negedge clk);
      v_valid = 1'b1; v_op = op; v_addr = addr; v_data = data;
      k = 0;
      while (s_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      if (s_ready !== 1'b1) begin
         chk("accept_timeout", 0, 1);
         v_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      // scramble the fields: the DUT must use what it captured
      v_valid = 1'b0; v_op = ~op; v_addr = ~addr; v_data = ~data;
      e.acc = cyc;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (a < NT) chk("bus_after_apply", s_bus[a*6 +: 6], e.data);
      k = 0;
      while (sbq.size() != 0 && k < 300) begin @(negedge clk); k++; end
      if (sbq.size() != 0) begin
         chk("rsp_timeout", 0, 1);
         sbq.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      model_reset();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [6*NT-1:0] snap;
      int acc_c [3];
      int nacc, p0, k;

      tbl[0]  = '{2'd0, 5'd5,  6'd37, 6'd37, 1'b0, 6, 5'd5};
      tbl[1]  = '{2'd0, 5'd19, 6'd62, 6'd62, 1'b0, 6, 5'd19};
      tbl[2]  = '{2'd1, 5'd19, 6'd0,  6'd63, 1'b0, 6, 5'd19};
      tbl[3]  = '{2'd1, 5'd19, 6'd0,  6'd63, 1'b1, 2, 5'd19};
      tbl[4]  = '{2'd0, 5'd0,  6'd0,  6'd0,  1'b0, 6, 5'd0};
      tbl[5]  = '{2'd2, 5'd0,  6'd0,  6'd0,  1'b1, 2, 5'd0};
      tbl[6]  = '{2'd3, 5'd19, 6'd0,  6'd63, 1'b0, 2, 5'd19};
      tbl[7]  = '{2'd3, 5'd20, 6'd0,  6'd0,  1'b1, 2, 5'd19};
      tbl[8]  = '{2'd0, 5'd31, 6'd5,  6'd0,  1'b1, 2, 5'd19};
      tbl[9]  = '{2'd2, 5'd5,  6'd0,  6'd36, 1'b0, 6, 5'd5};
      tbl[10] = '{2'd3, 5'd5,  6'd0,  6'd36, 1'b0, 2, 5'd5};

      // reset state, sampled while reset is held
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", s_ready, 1);
      chk("rst_busy", s_busy, 0);
      chk("rst_rsp_valid", s_rsp_valid, 0);
      chk("rst_rsp_data", s_rsp_data, 0);
      chk("rst_rsp_err", s_rsp_err, 0);
      chk("rst_dly_addr", s_dly_addr, 0);
      chk("rst_bus_zero", s_bus == '0, 1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // directed table on the SETTLE_CYCLES=4 instance
      for (int i = 0; i < 11; i++) begin
         e = model(tbl[i].op, tbl[i].addr, tbl[i].data);
         e.data = tbl[i].xd; e.err = tbl[i].xe; e.lat = tbl[i].lat; e.dly = tbl[i].xdly;
         snap = s_bus;
         do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, e);
         if (tbl[i].op == 2'd3 || tbl[i].xe)
            chk("bus_unchanged", s_bus == snap, 1);
      end

      // CMD_VALID held high across three INCs to channel 7
      p0 = npulse; nacc = 0;
      @(negedge clk);
      v_valid = 1'b1; v_op = 2'd1; v_addr = 5'd7; v_data = 6'd0;
      for (int c = 0; c < 60 && nacc < 3; c++) begin
         if (s_ready === 1'b1) begin
            @(posedge clk); #1;
            e = model(2'd1, 5'd7, 6'd0);
            e.acc = cyc;
            acc_c[nacc] = cyc;
            sbq.push_back(e);
            nacc++;
            if (nacc == 3) v_valid = 1'b0;
         end
         @(negedge clk);
      end
      v_valid = 1'b0;
      k = 0;
      while (sbq.size() != 0 && k < 100) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      chk("b2b_accepts", nacc, 3);
      if (nacc == 3) begin
         chk("b2b_gap0", acc_c[1] - acc_c[0], 7);
         chk("b2b_gap1", acc_c[2] - acc_c[1], 7);
      end
      chk("b2b_pulses", npulse - p0, 3);
      chk("b2b_tap7", s_bus[7*6 +: 6], 3);

      // reset during SETTLE of LOAD 50 to channel 3
      @(negedge clk);
      v_valid = 1'b1; v_op = 2'd0; v_addr = 5'd3; v_data = 6'd50;
      k = 0;
      while (s_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      v_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("mid_busy_before_rst", s_busy, 1);
      p0 = npulse;
      rst = 1'b1; #1;
      chk("mid_rst_busy", s_busy, 0);
      chk("mid_rst_ready", s_ready, 1);
      chk("mid_rst_tap3", s_bus[3*6 +: 6], 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (8) @(negedge clk);
      chk("mid_rst_no_rsp", npulse - p0, 0);
      e = model(2'd3, 5'd3, 6'd0);
      do_cmd(2'd3, 5'd3, 6'd0, e);

      // SETTLE_CYCLES=1 instance: directed write, then random traffic
      sel = 1'b1;
      msettle = 1;
      do_reset();
      e = model(2'd0, 5'd2, 6'd9);
      chk("s1_write_lat_model", e.lat, 3);
      do_cmd(2'd0, 5'd2, 6'd9, e);
      for (int i = 0; i < 80; i++) begin
         logic [1:0] op;
         logic [4:0] addr;
         logic [5:0] data;
         op   = 2'($urandom_range(0, 3));
         addr = 5'($urandom_range(0, 23));
         data = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
         e = model(op, addr, data);
         do_cmd(op, addr, data, e);
      end
      for (int i = 0; i < NT; i++)
         chk("s1_final_tap", s_bus[i*6 +: 6], mtap[i]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
